// File: rtl/neuron_loader.sv
// Byte-serial loader: packets fill shadow registers, and a STEP header commits them to the neuron outputs.
// Latency: the outputs and ce change on the edge that accepts the STEP header. ce stays high for one cycle.
// Backpressure: in_ready is 0 during reset and during the one-cycle STEP state. The sender holds the byte.
// Ports: in_data/in_valid/in_ready form the byte stream. w, x, shift, minus_teta, BN_factor and BN_addend
//        are the committed neuron parameters. ce is the one-cycle step enable. err is the sticky bad-header flag.
module neuron_loader #(
  parameter int n_stage = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2**n_stage-1:0] w,
  output logic [2**n_stage-1:0] x,
  output logic [2:0]           shift,
  output logic [n_stage+1:0]   minus_teta,
  output logic [3:0]           BN_factor,
  output logic [n_stage+1:0]   BN_addend,
  output logic                 ce,
  output logic                 err
);

  localparam int N  = 2**n_stage;
  localparam int NB = 2**(n_stage-3);
  // The counter is kept at least one bit wide so that the n_stage=3 case (one byte per vector) stays legal.
  localparam int CW = (n_stage > 3) ? (n_stage - 3) : 1;

  localparam logic [2:0] ID_W     = 3'd0;
  localparam logic [2:0] ID_X     = 3'd1;
  localparam logic [2:0] ID_CFG   = 3'd2;
  localparam logic [2:0] ID_TETA  = 3'd3;
  localparam logic [2:0] ID_BNADD = 3'd4;
  localparam logic [2:0] ID_STEP  = 3'd5;

  typedef enum logic [1:0] {
    S_HDR,
    S_PAYLOAD,
    S_STEP
  } state_t;

  state_t          state;
  logic [2:0]      id_q;
  logic [CW-1:0]   cnt;

  logic [N-1:0]       w_sh;
  logic [N-1:0]       x_sh;
  logic [2:0]         shift_sh;
  logic [3:0]         bnf_sh;
  logic [n_stage+1:0] teta_sh;
  logic [n_stage+1:0] bna_sh;

  logic xfer;
  logic last_byte;

  // in_ready is decoded from the state so that it is high in the first cycle after reset.
  assign in_ready  = rst_n && (state != S_STEP);
  assign xfer      = in_valid && in_ready;
  // Only the vector packets span several bytes. All other payloads are a single byte.
  assign last_byte = ((id_q != ID_W) && (id_q != ID_X)) || (cnt == CW'(NB - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_HDR;
      id_q       <= '0;
      cnt        <= '0;
      w_sh       <= '0;
      x_sh       <= '0;
      shift_sh   <= '0;
      bnf_sh     <= '0;
      teta_sh    <= '0;
      bna_sh     <= '0;
      w          <= '0;
      x          <= '0;
      shift      <= '0;
      minus_teta <= '0;
      BN_factor  <= '0;
      BN_addend  <= '0;
      ce         <= 1'b0;
      err        <= 1'b0;
    end else begin
      ce <= 1'b0;
      case (state)
        S_HDR: begin
          if (xfer) begin
            case (in_data[2:0])
              ID_W, ID_X, ID_CFG, ID_TETA, ID_BNADD: begin
                id_q  <= in_data[2:0];
                cnt   <= '0;
                state <= S_PAYLOAD;
              end
              ID_STEP: begin
                // Commit on the accepting edge so that the outputs and ce line up in the STEP cycle.
                w          <= w_sh;
                x          <= x_sh;
                shift      <= shift_sh;
                minus_teta <= teta_sh;
                BN_factor  <= bnf_sh;
                BN_addend  <= bna_sh;
                ce         <= 1'b1;
                state      <= S_STEP;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            case (id_q)
              ID_W:     w_sh[{cnt, 3'b000} +: 8] <= in_data;
              ID_X:     x_sh[{cnt, 3'b000} +: 8] <= in_data;
              ID_CFG: begin
                shift_sh <= in_data[2:0];
                bnf_sh   <= in_data[7:4];
              end
              ID_TETA:  teta_sh <= in_data[n_stage+1:0];
              ID_BNADD: bna_sh  <= in_data[n_stage+1:0];
              default: ;
            endcase
            cnt <= cnt + 1'b1;
            if (last_byte) begin
              state <= S_HDR;
            end
          end
        end
        S_STEP:  state <= S_HDR;
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
